// File: rtl/disp_bcd_driver_if.sv
// Parallel write port between the bus slave and the BCD/seven-segment driver.
// The master drives the data word and its write enable; the slave returns status and segments.
interface disp_bcd_driver_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  load;
    logic [DATA_WIDTH-1:0] din;
    logic                  busy;
    logic                  done;
    logic [6:0]            dout0;
    logic [6:0]            dout1;
    logic [6:0]            dout2;

    modport master (
        output load, din,
        input  busy, done, dout0, dout1, dout2
    );

    modport slave (
        input  load, din,
        output busy, done, dout0, dout1, dout2
    );
endinterface

// File: rtl/disp_bcd_driver.sv
// Iterative double-dabble binary-to-BCD converter driving three seven-segment digits.
// Digits update atomically when a conversion finishes; one start event may queue while busy.
module disp_bcd_driver #(
    parameter int DATA_WIDTH     = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    disp_bcd_driver_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t                state_q, state_d;
    logic                  load_q, load_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [11:0]           scratch_q, scratch_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic [3:0]            dig0_q, dig0_d;
    logic [3:0]            dig1_q, dig1_d;
    logic [3:0]            dig2_q, dig2_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                     start;
    logic [11:0]              adj;
    logic [DATA_WIDTH+11:0]   cat;

    function automatic logic [11:0] add3(input logic [11:0] s);
        logic [11:0] r;
        r = s;
        for (int i = 0; i < 3; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Encoding is held in active-low form; codes 10..15 blank the digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return SEG_ACTIVE_LOW ? s : ~s;
    endfunction

    always_comb begin
        state_d     = state_q;
        load_d      = bus.load;
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        dig0_d      = dig0_q;
        dig1_d      = dig1_q;
        dig2_d      = dig2_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        start = bus.load & ~load_q;
        adj   = add3(scratch_q);
        cat   = {adj, shift_q} << 1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bus.din;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                    busy_d    = 1'b1;
                end
            end
            SHIFT: begin
                scratch_d = cat[DATA_WIDTH+11:DATA_WIDTH];
                shift_d   = cat[DATA_WIDTH-1:0];
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = UPDATE;
                if (start) begin
                    pend_d      = 1'b1;
                    pend_data_d = bus.din;
                end
            end
            UPDATE: begin
                dig0_d = scratch_q[3:0];
                dig1_d = scratch_q[7:4];
                dig2_d = scratch_q[11:8];
                done_d = 1'b1;
                scratch_d = '0;
                cnt_d     = '0;
                // A queued value starts now; an event arriving this very cycle queues behind it.
                if (pend_q) begin
                    shift_d = pend_data_q;
                    state_d = SHIFT;
                    pend_d  = start;
                    if (start) pend_data_d = bus.din;
                end else if (start) begin
                    shift_d = bus.din;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            load_q      <= 1'b0;
            shift_q     <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            dig0_q      <= '0;
            dig1_q      <= '0;
            dig2_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_q      <= load_d;
            shift_q     <= shift_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            dig0_q      <= dig0_d;
            dig1_q      <= dig1_d;
            dig2_q      <= dig2_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.dout0 = seg_encode(dig0_q);
    assign bus.dout1 = seg_encode(dig1_q);
    assign bus.dout2 = seg_encode(dig2_q);
endmodule
